// File: rtl/servo_pkg.sv
// servo_pkg: command codes, status characters, default timing and motion states shared by the servo controller
//   Command codes 1-6 are shared with the UART command decoder.
//   Status bytes are the ASCII characters reported on current_state_msg.
package servo_pkg;

    localparam logic [2:0] CMD_IDLE     = 3'd1;
    localparam logic [2:0] CMD_PRELOAD  = 3'd2;
    localparam logic [2:0] CMD_DELIVERY = 3'd3;
    localparam logic [2:0] CMD_TOP      = 3'd4;
    localparam logic [2:0] CMD_INC      = 3'd5;
    localparam logic [2:0] CMD_DEC      = 3'd6;

    localparam logic [7:0] MSG_IDLE     = "I";
    localparam logic [7:0] MSG_PRELOAD  = "P";
    localparam logic [7:0] MSG_DELIVERY = "E";
    localparam logic [7:0] MSG_TOP      = "T";
    localparam logic [7:0] MSG_HOLD     = "H";
    localparam logic [7:0] MSG_MOVING   = "M";

    // 27 MHz clock: 20 ms frame, 1.0-2.0 ms pulse range
    localparam int DEF_PWM_PERIOD   = 540000;
    localparam int DEF_PW_MIN       = 27000;
    localparam int DEF_PW_MAX       = 54000;
    localparam int DEF_POS_IDLE     = 27000;
    localparam int DEF_POS_PRELOAD  = 33750;
    localparam int DEF_POS_DELIVERY = 40500;
    localparam int DEF_POS_TOP      = 54000;
    localparam int DEF_STEP         = 270;
    localparam int DEF_NUDGE        = 1350;
    localparam int DEF_CW           = 20;

    typedef enum logic {SETTLED, MOVING} motion_e;

endpackage

// File: rtl/servo_frame_gen.sv
// servo_frame_gen: PWM frame counter and pulse comparator
//   clk, reset_n : clock, synchronous active-low reset
//   pw_cur       : pulse width in cycles for the running frame
//   pwm_out      : registered PWM output, high for pw_cur cycles per frame
//   frame_end    : high on the last cycle of each frame
module servo_frame_gen
    import servo_pkg::*;
#(
    parameter int PWM_PERIOD = DEF_PWM_PERIOD,
    parameter int CW         = DEF_CW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CW-1:0] pw_cur,
    output logic          pwm_out,
    output logic          frame_end
);

    localparam logic [CW-1:0] LAST = CW'(PWM_PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic          pwm_q;

    assign frame_end = cnt_q == LAST;
    assign pwm_out   = pwm_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= frame_end ? '0 : cnt_q + 1'b1;
            pwm_q <= cnt_q < pw_cur;
        end
    end

endmodule

// File: rtl/servo_pwm_ctrl.sv
// servo_pwm_ctrl: slew-limited 50 Hz servo PWM driven by decoded position commands
//   clk, reset_n      : clock, synchronous active-low reset
//   state_desired     : command code (1 IDLE, 2 PRELOAD, 3 DELIVERY, 4 TOP, 5 INC, 6 DEC)
//   command_valid     : single-cycle strobe qualifying state_desired
//   pwm_out           : registered servo PWM
//   target_reached    : high while the pulse width is settled at target
//   current_state_msg : ASCII status, "M" while moving, else the last command tag
module servo_pwm_ctrl
    import servo_pkg::*;
#(
    parameter int PWM_PERIOD   = DEF_PWM_PERIOD,
    parameter int PW_MIN       = DEF_PW_MIN,
    parameter int PW_MAX       = DEF_PW_MAX,
    parameter int POS_IDLE     = DEF_POS_IDLE,
    parameter int POS_PRELOAD  = DEF_POS_PRELOAD,
    parameter int POS_DELIVERY = DEF_POS_DELIVERY,
    parameter int POS_TOP      = DEF_POS_TOP,
    parameter int STEP         = DEF_STEP,
    parameter int NUDGE        = DEF_NUDGE,
    parameter int CW           = DEF_CW
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] state_desired,
    input  logic       command_valid,
    output logic       pwm_out,
    output logic       target_reached,
    output logic [7:0] current_state_msg
);

    if (!(PW_MIN <= POS_IDLE && POS_IDLE <= PW_MAX &&
          PW_MIN <= POS_PRELOAD && POS_PRELOAD <= PW_MAX &&
          PW_MIN <= POS_DELIVERY && POS_DELIVERY <= PW_MAX &&
          PW_MIN <= POS_TOP && POS_TOP <= PW_MAX &&
          PW_MAX < PWM_PERIOD && PWM_PERIOD <= 2**CW - 1 && STEP >= 1)) begin : g_bad_params
        $error("servo_pwm_ctrl: illegal timing parameters");
    end

    localparam logic [CW:0] MAX_W    = (CW+1)'(PW_MAX);
    localparam logic [CW:0] DEC_FLOOR = (CW+1)'(PW_MIN + NUDGE);

    logic [CW-1:0] pw_cur_q, pw_cur_d, pw_tgt_q, pw_tgt_d;
    logic [7:0]    tag_q, tag_d, msg_q;
    motion_e       state_q, state_d;
    logic          tr_q, frame_end;
    logic [CW:0]   cur_w, tgt_w, cur_up, tgt_up;

    servo_frame_gen #(.PWM_PERIOD(PWM_PERIOD), .CW(CW)) u_frame (
        .clk       (clk),
        .reset_n   (reset_n),
        .pw_cur    (pw_cur_q),
        .pwm_out   (pwm_out),
        .frame_end (frame_end)
    );

    // All arithmetic is one bit wider than the registers so sums clamp before wrapping
    always_comb begin
        cur_w    = {1'b0, pw_cur_q};
        tgt_w    = {1'b0, pw_tgt_q};
        cur_up   = cur_w + (CW+1)'(STEP);
        tgt_up   = tgt_w + (CW+1)'(NUDGE);
        pw_tgt_d = pw_tgt_q;
        tag_d    = tag_q;
        if (command_valid) begin
            case (state_desired)
                CMD_IDLE:     begin pw_tgt_d = CW'(POS_IDLE);     tag_d = MSG_IDLE;     end
                CMD_PRELOAD:  begin pw_tgt_d = CW'(POS_PRELOAD);  tag_d = MSG_PRELOAD;  end
                CMD_DELIVERY: begin pw_tgt_d = CW'(POS_DELIVERY); tag_d = MSG_DELIVERY; end
                CMD_TOP:      begin pw_tgt_d = CW'(POS_TOP);      tag_d = MSG_TOP;      end
                CMD_INC: begin
                    pw_tgt_d = tgt_up > MAX_W ? CW'(PW_MAX) : tgt_up[CW-1:0];
                    tag_d    = MSG_HOLD;
                end
                CMD_DEC: begin
                    pw_tgt_d = tgt_w < DEC_FLOOR ? CW'(PW_MIN) : pw_tgt_q - CW'(NUDGE);
                    tag_d    = MSG_HOLD;
                end
                default: ;
            endcase
        end
        // Ramp steps only at frame boundaries against the target held during that frame
        pw_cur_d = !frame_end          ? pw_cur_q :
                   cur_w < tgt_w       ? (cur_up > tgt_w ? pw_tgt_q : cur_up[CW-1:0]) :
                   cur_w > tgt_w       ? (cur_w < tgt_w + (CW+1)'(STEP) ? pw_tgt_q : pw_cur_q - CW'(STEP)) :
                                         pw_cur_q;
        state_d  = state_q == SETTLED ? (pw_cur_q != pw_tgt_q ? MOVING : SETTLED)
                                      : (pw_cur_q == pw_tgt_q ? SETTLED : MOVING);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pw_cur_q <= CW'(POS_IDLE);
            pw_tgt_q <= CW'(POS_IDLE);
            tag_q    <= MSG_IDLE;
            state_q  <= SETTLED;
            tr_q     <= 1'b0;
            msg_q    <= MSG_IDLE;
        end else begin
            pw_cur_q <= pw_cur_d;
            pw_tgt_q <= pw_tgt_d;
            tag_q    <= tag_d;
            state_q  <= state_d;
            tr_q     <= state_d == SETTLED;
            msg_q    <= state_d == MOVING ? MSG_MOVING : tag_q;
        end
    end

    assign target_reached    = tr_q;
    assign current_state_msg = msg_q;

endmodule

// File: doc/servo_pwm_ctrl.md
Name: servo_pwm_ctrl

Overview:
Downstream consumer of the UART command decoder. It takes the 3-bit position command (state_desired, qualified by command_valid) and drives a 50 Hz servo PWM output. The pulse width ramps toward the commanded target at a bounded slew rate. It returns target_reached and an ASCII state byte (current_state_msg), which the UART decoder uses for its "R" event and its 100 ms status report.

Parameters:
PWM_PERIOD, 540000, clk cycles per PWM frame (20 ms @ 27 MHz)
PW_MIN, 27000, minimum pulse width in cycles (1.0 ms)
PW_MAX, 54000, maximum pulse width in cycles (2.0 ms)
POS_IDLE, 27000, preset pulse width for IDLE
POS_PRELOAD, 33750, preset pulse width for PRELOAD
POS_DELIVERY, 40500, preset pulse width for DELIVERY
POS_TOP, 54000, preset pulse width for TOP
STEP, 270, maximum pulse-width change per frame
NUDGE, 1350, target delta for INCREMENT/DECREMENT
CW, 20, width of counters and pulse-width registers

Ports:
clk  in  1  system clock, 27 MHz
reset_n  in  1  synchronous, active-low reset
state_desired  in  3  command code: 1 IDLE, 2 PRELOAD, 3 DELIVERY, 4 TOP, 5 INCREMENT, 6 DECREMENT
command_valid  in  1  single-cycle strobe qualifying state_desired
pwm_out  out  1  servo PWM, registered
target_reached  out  1  level: high while settled at target
current_state_msg  out  8  ASCII status byte

Behaviour:
- Clock and reset: clk is the clock; reset_n is synchronous and active-low.
- Reset values:
  - pwm_out=0, frame counter=0.
  - pw_cur=pw_tgt=POS_IDLE, tag='I'.
  - Motion FSM=SETTLED, target_reached=0, current_state_msg="I".
  - Reset asserted mid-ramp or mid-frame aborts immediately to these values.
- Frame generator:
  - cnt counts 0..PWM_PERIOD-1, then wraps to 0.
  - frame_end=1 when cnt==PWM_PERIOD-1.
  - pwm_out <= (cnt < pw_cur), so it is high for exactly pw_cur cycles per frame, with 1-cycle latency.
- Command decode (on command_valid):
  - Codes 1-4: pw_tgt <= preset; tag <= 'I','P','E','T' respectively.
  - Code 5: pw_tgt <= min(pw_tgt+NUDGE, PW_MAX); tag <= 'H'.
  - Code 6: pw_tgt <= max(pw_tgt-NUDGE, PW_MIN); tag <= 'H'.
  - Codes 0 and 7 are ignored; no register changes.
  - Arithmetic is done in CW+1 bits so there is no wrap before clamping.
  - The new target is visible the next cycle.
- Ramp: updates only on frame_end, so there is no mid-frame glitch.
  - If pw_cur<pw_tgt: pw_cur <= min(pw_cur+STEP, pw_tgt).
  - If pw_cur>pw_tgt: pw_cur <= max(pw_cur-STEP, pw_tgt).
  - A command arriving in the same cycle as frame_end: the ramp uses the old pw_tgt; the new target is latched for the next frame.
- Motion FSM:
  - SETTLED->MOVING when pw_cur!=pw_tgt.
  - MOVING->SETTLED when pw_cur==pw_tgt.
  - Evaluated every cycle from registered values.
  - target_reached <= (next state==SETTLED), i.e. it follows the FSM with 1-cycle latency.
  - Consequences:
    - After reset release, target_reached rises 1 cycle later.
    - A new differing target drops target_reached 1 cycle after the command is accepted.
    - A command equal to the current target (or a clamped nudge) leaves target_reached high, so no new rising edge is produced.
    - A retarget while MOVING produces no intermediate high.
- current_state_msg (registered): "M" while MOVING; tag while SETTLED.
- Parameter legality: PW_MIN <= presets <= PW_MAX < PWM_PERIOD <= 2^CW-1, and STEP >= 1. These are enforced by elaboration-time checks.

Decomposition:
- Package servo_pkg holds:
  - Command codes 1-6, shared with the UART decoder.
  - ASCII message constants 'I','P','E','T','H','M'.
  - Default timing constants.
  - Motion FSM enum {SETTLED, MOVING}.
- One sub-module, servo_frame_gen: the counter plus comparator. Inputs clk, reset_n, pw_cur; outputs pwm_out and frame_end.
- The parent holds command decode, target/tag registers, the ramp, and the FSM.

Test Plan:
- Reset, then release:
  - Required: target_reached=0 during reset and 1 one cycle after release.
  - Required: msg="I".
  - Required: pwm_out high for exactly 27000 cycles in each 540000-cycle frame.
- TOP (4) from IDLE:
  - Required: target_reached=0 and msg="M" the next cycle.
  - Required: pw_cur reaches 54000 after 100 frame_ends.
  - Required: target_reached rises 1 cycle later with msg="T"; measured high time is 54000.
- INCREMENT while settled at TOP:
  - Required: pw_tgt clamps at 54000 and target_reached stays 1 with no falling edge.
  - Required: msg="H".
- PRELOAD, settle, then DECREMENT:
  - Required: pw_tgt=32400; ramp completes in 5 frames; final msg="H".
  - Then DECREMENT at IDLE: required clamp at 27000.
- Retarget mid-ramp: TOP issued, then IDLE at pw_cur=40500 (after 50 frames):
  - Required: pw_cur descends to 27000 over 50 frames.
  - Required: target_reached stays 0 throughout, then rises once.
- Edge cases:
  - state_desired=0 or 7 with command_valid: required no change to any register.
  - reset_n low for 1 cycle mid-ramp: required pwm_out=0, cnt=0, pw_cur=27000, msg="I".
